// File: rtl/interboard_link_tx.sv
// rtl/interboard_link_tx.sv - transmit half of the board-to-board link, two-beat four-phase handshake
module interboard_link_tx #(
    parameter int SETUP_CYCLES = 4,
    parameter int TIMEOUT      = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       transmit,
    input  logic       ctrl_en,
    input  logic [2:0] ctrl_msg_type,
    input  logic [4:0] ctrl_number,
    input  logic       Ack_in,
    output logic       Request_out,
    output logic [5:0] inter_data_out,
    output logic       inter_ready,
    output logic       tx_done,
    output logic       tx_timeout
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(SETUP_CYCLES + 1);
    localparam logic [SW-1:0] SETUP_MAX = SW'(SETUP_CYCLES);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_SAT    = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} state_t;

    state_t         state_q, state_d;
    logic           ack_m_q, ack_s_q;
    logic [SW-1:0]  setup_cnt_q, setup_cnt_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           beat_q, beat_d;
    logic [4:0]     num_q, num_d;
    logic           req_q, req_d;
    logic [5:0]     data_q, data_d;
    logic           ready_q, ready_d;
    logic           done_q, done_d;
    logic           tmo_q, tmo_d;
    logic           to_hit;
    logic           abort;
    logic [TW-1:0]  to_inc;

    assign to_hit = (to_cnt_q >= TO_LAST);
    assign to_inc = (to_cnt_q == TO_SAT) ? to_cnt_q : to_cnt_q + TW'(1);

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        to_cnt_d    = to_cnt_q;
        beat_d      = beat_q;
        num_d       = num_q;
        req_d       = req_q;
        data_d      = data_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        tmo_d       = 1'b0;
        abort       = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                // a strobe coinciding with the completion pulse is dropped
                if (transmit && !done_q && !tmo_q) begin
                    num_d       = ctrl_number;
                    data_d      = {2'b10, ctrl_msg_type, ctrl_en};
                    beat_d      = 1'b0;
                    setup_cnt_d = '0;
                    to_cnt_d    = '0;
                    ready_d     = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                req_d = 1'b0;
                if (setup_cnt_q != SETUP_MAX) begin
                    setup_cnt_d = setup_cnt_q + SW'(1);
                end else if (!ack_s_q) begin
                    req_d    = 1'b1;
                    to_cnt_d = '0;
                    state_d  = REQ;
                end else if (to_hit) begin
                    abort = 1'b1;
                end else begin
                    to_cnt_d = to_inc;
                end
            end
            REQ: begin
                // ack is checked first so it beats a same-cycle timeout
                if (ack_s_q) begin
                    req_d    = 1'b0;
                    to_cnt_d = '0;
                    state_d  = REL;
                end else if (to_hit) begin
                    abort = 1'b1;
                end else begin
                    to_cnt_d = to_inc;
                end
            end
            REL: begin
                if (!ack_s_q) begin
                    to_cnt_d = '0;
                    if (!beat_q) begin
                        data_d      = {1'b0, num_q};
                        beat_d      = 1'b1;
                        setup_cnt_d = '0;
                        state_d     = SETUP;
                    end else begin
                        done_d  = 1'b1;
                        data_d  = '0;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end
                end else if (to_hit) begin
                    abort = 1'b1;
                end else begin
                    to_cnt_d = to_inc;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            req_d   = 1'b0;
            data_d  = '0;
            tmo_d   = 1'b1;
            ready_d = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ack_m_q     <= 1'b0;
            ack_s_q     <= 1'b0;
            setup_cnt_q <= '0;
            to_cnt_q    <= '0;
            beat_q      <= 1'b0;
            num_q       <= '0;
            req_q       <= 1'b0;
            data_q      <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_m_q     <= Ack_in;
            ack_s_q     <= ack_m_q;
            setup_cnt_q <= setup_cnt_d;
            to_cnt_q    <= to_cnt_d;
            beat_q      <= beat_d;
            num_q       <= num_d;
            req_q       <= req_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
        end
    end

    assign Request_out    = req_q;
    assign inter_data_out = data_q;
    assign inter_ready    = ready_q;
    assign tx_done        = done_q;
    assign tx_timeout     = tmo_q;
endmodule
